// File: rtl/ssd_pkg.sv
// Shared constants and types for the seven-segment bus reader.
package ssd_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BLANK = 4'hF;

    // Segment patterns, a..g on bits 6..0, active-high
    localparam logic [6:0] SEG_0 = 7'h7E;
    localparam logic [6:0] SEG_1 = 7'h30;
    localparam logic [6:0] SEG_2 = 7'h6D;
    localparam logic [6:0] SEG_3 = 7'h79;
    localparam logic [6:0] SEG_4 = 7'h33;
    localparam logic [6:0] SEG_5 = 7'h5B;
    localparam logic [6:0] SEG_6 = 7'h5F;
    localparam logic [6:0] SEG_7 = 7'h70;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h7B;

endpackage

// File: rtl/ssd_pattern_decode.sv
// Combinational segment-pattern to BCD decoder; flags patterns that are not digits 0-9.
module ssd_pattern_decode
    import ssd_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic       o_valid_c,
    output bcd_t       o_bcd_c
);

    always_comb begin
        o_valid_c = 1'b1;
        o_bcd_c   = BLANK;
        case (i_seg)
            SEG_0:   o_bcd_c = 4'd0;
            SEG_1:   o_bcd_c = 4'd1;
            SEG_2:   o_bcd_c = 4'd2;
            SEG_3:   o_bcd_c = 4'd3;
            SEG_4:   o_bcd_c = 4'd4;
            SEG_5:   o_bcd_c = 4'd5;
            SEG_6:   o_bcd_c = 4'd6;
            SEG_7:   o_bcd_c = 4'd7;
            SEG_8:   o_bcd_c = 4'd8;
            SEG_9:   o_bcd_c = 4'd9;
            default: o_valid_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/ssd_reader.sv
// Recovers debounced BCD digits from a multiplexed seven-segment bus and hands
// changed frames on with valid/ready. Define ERR_CNT_EN to add the err_cnt output.
module ssd_reader
    import ssd_pkg::*;
#(
    parameter int unsigned NDIG   = 4,
    parameter int unsigned STABLE = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sample_en,
    input  logic [6:0]          seg,
    input  logic [NDIG-1:0]     dig_sel,
    output logic [4*NDIG-1:0]   out_bcd,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                pat_err
`ifdef ERR_CNT_EN
    ,
    output logic [15:0]         err_cnt
`endif
);

    localparam int unsigned CW = $clog2(STABLE + 1);
    localparam int unsigned IW = (NDIG > 1) ? $clog2(NDIG) : 1;

    bcd_t                r_cand [NDIG];
    logic [CW-1:0]       r_cnt  [NDIG];
    bcd_t                r_comm [NDIG];
    logic                r_dirty;
    logic [4*NDIG-1:0]   r_bcd;
    logic                r_valid;
    logic                r_pat_err;

    logic                w_dec_valid;
    bcd_t                w_dec_bcd;
    logic                w_sample;
    logic                w_wrap;
    logic [IW-1:0]       w_idx;
    bcd_t                w_cand_nxt;
    logic [CW-1:0]       w_cnt_nxt;
    logic                w_commit;
    logic                w_bad;
    logic [4*NDIG-1:0]   w_comm_flat;
    logic                w_dirty_eff;
    logic                w_load;
    logic                w_accept;

    ssd_pattern_decode u_decode (
        .i_seg     (seg),
        .o_valid_c (w_dec_valid),
        .o_bcd_c   (w_dec_bcd)
    );

    assign w_sample = sample_en && $onehot(dig_sel);
    assign w_wrap   = w_sample && dig_sel[NDIG-1];

    // One-hot select to digit index; only meaningful when w_sample is set
    always_comb begin
        w_idx = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (dig_sel[i]) w_idx = IW'(i);
        end
    end

    // Debounce update for the selected digit
    always_comb begin
        w_cand_nxt = r_cand[w_idx];
        w_cnt_nxt  = r_cnt[w_idx];
        w_commit   = 1'b0;
        w_bad      = 1'b0;
        if (w_sample) begin
            if (!w_dec_valid) begin
                w_cnt_nxt = '0;
                w_bad     = 1'b1;
            end else if (w_dec_bcd == r_cand[w_idx]) begin
                if (r_cnt[w_idx] != CW'(STABLE)) w_cnt_nxt = r_cnt[w_idx] + CW'(1);
            end else begin
                w_cand_nxt = w_dec_bcd;
                w_cnt_nxt  = CW'(1);
            end
            w_commit = w_dec_valid && (w_cnt_nxt == CW'(STABLE))
                       && (w_cand_nxt != r_comm[w_idx]);
        end
    end

    // Committed digits as they will be after this cycle, so a wrap captures same-cycle commits
    always_comb begin
        w_comm_flat = '0;
        for (int i = 0; i < NDIG; i++) begin
            w_comm_flat[4*i +: 4] = (w_commit && (w_idx == IW'(i))) ? w_cand_nxt : r_comm[i];
        end
    end

    assign w_dirty_eff = r_dirty || w_commit;
    assign w_accept    = r_valid && out_ready;
    assign w_load      = w_wrap && w_dirty_eff && (!r_valid || out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NDIG; i++) begin
                r_cand[i] <= '0;
                r_cnt[i]  <= '0;
                r_comm[i] <= BLANK;
            end
            r_dirty   <= 1'b0;
            r_bcd     <= '0;
            r_valid   <= 1'b0;
            r_pat_err <= 1'b0;
        end else begin
            r_pat_err <= w_bad;
            if (w_sample) begin
                r_cand[w_idx] <= w_cand_nxt;
                r_cnt[w_idx]  <= w_cnt_nxt;
                if (w_commit) r_comm[w_idx] <= w_cand_nxt;
            end
            if (w_load) begin
                r_bcd   <= w_comm_flat;
                r_valid <= 1'b1;
                r_dirty <= 1'b0;
            end else begin
                r_dirty <= w_dirty_eff;
                if (w_accept) r_valid <= 1'b0;
            end
        end
    end

    assign out_bcd   = r_bcd;
    assign out_valid = r_valid;
    assign pat_err   = r_pat_err;

`ifdef ERR_CNT_EN
    logic [15:0] r_err_cnt;

    // Error counter clears on frame acceptance, otherwise saturates
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (w_accept) begin
            r_err_cnt <= '0;
        end else if (r_pat_err && (r_err_cnt != 16'hFFFF)) begin
            r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_ssd_reader.sv
// Randomised scoreboard bench for ssd_reader with a digit-level reference model.
module tb_ssd_reader;

    localparam int NDIG   = 4;
    localparam int STABLE = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sample_en;
    logic [6:0]  seg;
    logic [3:0]  dig_sel;
    logic [15:0] out_bcd;
    logic        out_valid;
    logic        out_ready;
    logic        pat_err;
`ifdef ERR_CNT_EN
    logic [15:0] err_cnt;
`endif

    ssd_reader #(.NDIG(NDIG), .STABLE(STABLE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sample_en (sample_en),
        .seg       (seg),
        .dig_sel   (dig_sel),
        .out_bcd   (out_bcd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pat_err   (pat_err)
`ifdef ERR_CNT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int frames = 0;

    logic [6:0] pats [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                              7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

    // Reference model state
    int          m_cand [NDIG];
    int          m_cnt  [NDIG];
    int          m_comm [NDIG];
    bit          m_dirty;
    bit          m_valid;
    bit          m_pat;
    logic [15:0] exp_q [$];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int seg2dig(logic [6:0] s);
        for (int i = 0; i < 10; i++) if (pats[i] == s) return i;
        return -1;
    endfunction

    function automatic logic [6:0] dig_pat(logic [3:0] d);
        if (d < 4'd10) return pats[d];
        return 7'h00;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NDIG; i++) begin
            m_cand[i] = 0;
            m_cnt[i]  = 0;
            m_comm[i] = 15;
        end
        m_dirty = 0;
        m_valid = 0;
        m_pat   = 0;
        exp_q.delete();
    endtask

    // Apply one cycle of inputs, advance the model, then check the registered outputs
    task automatic step(bit en, logic [6:0] s, logic [3:0] sel);
        int          d;
        int          idx;
        bit          wrap;
        logic [15:0] f;
        sample_en = en;
        seg       = s;
        dig_sel   = sel;
        m_pat = 0;
        wrap  = 0;
        if (en && $countones(sel) == 1) begin
            idx = 0;
            for (int i = 0; i < NDIG; i++) if (sel[i]) idx = i;
            d = seg2dig(s);
            if (d < 0) begin
                m_cnt[idx] = 0;
                m_pat = 1;
            end else begin
                if (d == m_cand[idx]) begin
                    m_cnt[idx] = (m_cnt[idx] + 1 > STABLE) ? STABLE : m_cnt[idx] + 1;
                end else begin
                    m_cand[idx] = d;
                    m_cnt[idx]  = 1;
                end
                if (m_cnt[idx] == STABLE && m_cand[idx] != m_comm[idx]) begin
                    m_comm[idx] = m_cand[idx];
                    m_dirty = 1;
                end
            end
            wrap = (idx == NDIG - 1);
        end
        if (wrap && m_dirty && (!m_valid || out_ready)) begin
            for (int i = 0; i < NDIG; i++) f[4*i +: 4] = 4'(m_comm[i]);
            exp_q.push_back(f);
            m_valid = 1;
            m_dirty = 0;
        end else if (m_valid && out_ready) begin
            m_valid = 0;
        end
        @(posedge clk);
        #1;
        check("pat_err", 32'(pat_err), 32'(m_pat));
        check("out_valid", 32'(out_valid), 32'(m_valid));
    endtask

    task automatic idle(int n);
        repeat (n) step(1'b0, 7'h00, 4'b0000);
    endtask

    task automatic scan(logic [15:0] f, int reps);
        repeat (reps) begin
            for (int i = 0; i < NDIG; i++) step(1'b1, dig_pat(f[4*i +: 4]), 4'(1 << i));
        end
    endtask

    // Monitor: every accepted frame must match the oldest predicted frame
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            frames++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL frame: unexpected frame %0h, none predicted", out_bcd);
            end else begin
                check("frame", 32'(out_bcd), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        logic [15:0] disp;
        int          ptr;
        logic [3:0]  sel;
        logic [6:0]  s;
        bit          en;

        rst_n     = 1'b0;
        sample_en = 1'b0;
        seg       = 7'h00;
        dig_sel   = 4'b0000;
        out_ready = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_bcd", 32'(out_bcd), 32'd0);
        check("rst_pat_err", 32'(pat_err), 32'd0);
        rst_n = 1'b1;

        // Basic capture
        scan(16'h4321, 3);
        idle(2);
        check("frames_t1", 32'(frames), 32'd1);
        check("bcd_t1", 32'(out_bcd), 32'h4321);

        // Unchanged digits produce no frame
        scan(16'h4321, 2);
        idle(2);
        check("frames_t2", 32'(frames), 32'd1);

        // Unstable digit does not commit, then commits
        scan(16'h4325, 2);
        scan(16'h4326, 1);
        idle(2);
        check("frames_t3a", 32'(frames), 32'd1);
        scan(16'h4326, 3);
        idle(2);
        check("frames_t3b", 32'(frames), 32'd2);
        check("bcd_t3", 32'(out_bcd), 32'h4326);

        // Invalid pattern and multi-hot select
        step(1'b1, 7'h00, 4'b0100);
        step(1'b1, pats[8], 4'b0011);
        idle(2);
        check("frames_t4", 32'(frames), 32'd2);

        // Back-pressure coalesces changes into one pending frame
        out_ready = 1'b0;
        scan(16'h9321, 3);
        scan(16'h7321, 3);
        idle(3);
        check("frames_t5a", 32'(frames), 32'd2);
        check("bcd_t5a", 32'(out_bcd), 32'h9321);
        out_ready = 1'b1;
        idle(2);
        scan(16'h7321, 1);
        idle(2);
        check("frames_t5b", 32'(frames), 32'd4);
        check("bcd_t5b", 32'(out_bcd), 32'h7321);

        // Asynchronous reset mid-scan with a frame pending
        out_ready = 1'b0;
        scan(16'h5555, 3);
        step(1'b1, pats[5], 4'b0001);
        step(1'b1, pats[5], 4'b0010);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst6_valid", 32'(out_valid), 32'd0);
        check("rst6_bcd", 32'(out_bcd), 32'd0);
        check("rst6_pat_err", 32'(pat_err), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (3) step(1'b1, pats[8], 4'b1000);
        idle(2);
        check("bcd_blank", 32'(out_bcd), 32'h8FFF);

        // Randomised traffic
        disp = 16'h1234;
        ptr  = 0;
        repeat (3000) begin
            if ($urandom % 60 == 0) disp[4*ptr +: 4] = 4'($urandom % 10);
            out_ready = 1'($urandom % 2);
            en  = ($urandom % 8) != 0;
            sel = 4'(1 << ptr);
            if ($urandom % 20 == 0) sel = 4'($urandom);
            s = dig_pat(disp[4*ptr +: 4]);
            if ($urandom % 40 == 0) s = 7'($urandom);
            step(en, s, sel);
            if (en) ptr = (ptr + 1) % NDIG;
        end

        out_ready = 1'b1;
        idle(5);
        check("drain", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
